led_fade_driver: RTL and testbench

- Downstream consumer of the 4-bit LED count pattern produced by the LED counter stage.
- Converts each on/off bit into a PWM-driven LED output that ramps smoothly up or down instead of switching hard.
- Sits between the counter's registered led[3:0] and the board LED pins.
- One free-running PWM period counter is shared by all channels; each channel has its own duty register.

---
 rtl/led_fade_driver.sv | 197 +++++++++++++++++++
 tb/tb_led_fade_driver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_driver.sv
// led_fade_driver: four-channel LED fader placed after the LED counter stage.
//
// Each bit of the on/off pattern from the counter drives one channel. Instead of
// switching hard, the channel duty ramps toward 0 or full scale (DMAX) by STEP_SIZE
// once every STEP_DIV clocks. A single free-running PWM counter is shared by all
// channels and turns each duty into a pulse-width-modulated LED drive.
//
// Ports:
//   clock       system clock
//   n_reset     synchronous active-low reset, sampled on posedge clock
//   pattern_in  target on/off pattern; bit i = 1 fades channel i up to full
//   led_out     registered PWM drive per channel, active-high
//   fading      registered per-channel status, 1 while duty[i] != target[i]
//   duty_mon    live linear duty registers {duty3, duty2, duty1, duty0}
//
// Parameters:
//   PWM_BITS    duty / PWM counter width; DMAX = 2^PWM_BITS-1, PWM period = DMAX clocks
//   STEP_DIV    clocks between fade step ticks (>= 2)
//   STEP_SIZE   duty change per step tick (1..DMAX)
//
// Build option:
//   LED_FADE_GAMMA_EN  when defined, the PWM shadow register takes a squared
//                      (perceptually linear) version of the duty; full scale is
//                      kept at full scale. When undefined, the shadow takes the
//                      duty directly and no multiplier exists.

module led_fade_driver #(
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned STEP_DIV  = 100000,
  parameter int unsigned STEP_SIZE = 1
) (
  input  logic                  clock,
  input  logic                  n_reset,
  input  logic [3:0]            pattern_in,
  output logic [3:0]            led_out,
  output logic [3:0]            fading,
  output logic [4*PWM_BITS-1:0] duty_mon
);

  localparam int unsigned NumCh = 4;
  localparam int unsigned StepW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef logic [PWM_BITS-1:0] duty_t;
  // One extra bit so that duty + STEP_SIZE can be checked against DMAX before
  // it is stored; the stored duty never wraps.
  typedef logic [PWM_BITS:0]   wide_t;
  typedef logic [StepW-1:0]    step_t;

  localparam duty_t DMax     = {PWM_BITS{1'b1}};
  localparam wide_t DMaxW    = {1'b0, DMax};
  localparam wide_t StepInc  = wide_t'(STEP_SIZE);
  localparam step_t StepLast = step_t'(STEP_DIV - 1);
  localparam duty_t PwmLast  = DMax - duty_t'(1);

  // Per-channel ramp state, derived each cycle from duty versus target.
  typedef enum logic [1:0] {
    StOff,
    StRising,
    StOn,
    StFalling
  } ch_state_e;

  // Value that the PWM shadow register takes for a given duty.
`ifdef LED_FADE_GAMMA_EN
  function automatic duty_t shade(input duty_t d);
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
    // Squaring would drop full scale to just below DMAX; keep full on solid.
    if (d == DMax) begin
      return DMax;
    end
    return duty_t'(sq >> PWM_BITS);
  endfunction
`else
  function automatic duty_t shade(input duty_t d);
    return d;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [3:0] pat_q;
  step_t      step_cnt_q, step_cnt_d;
  duty_t      pwm_cnt_q, pwm_cnt_d;
  duty_t      duty_q   [NumCh];
  duty_t      duty_d   [NumCh];
  duty_t      shadow_q [NumCh];
  duty_t      shadow_d [NumCh];
  logic [3:0] led_q, led_d;
  logic [3:0] fading_q, fading_d;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic      step_tick;
  logic      pwm_wrap;
  duty_t     target [NumCh];
  ch_state_e st     [NumCh];

  assign step_tick = (step_cnt_q == StepLast);
  assign pwm_wrap  = (pwm_cnt_q == PwmLast);

  always_comb begin
    for (int unsigned i = 0; i < NumCh; i++) begin
      target[i] = pat_q[i] ? DMax : '0;
      st[i]     = StOff;
      if (duty_q[i] == target[i]) begin
        st[i] = (target[i] == DMax) ? StOn : StOff;
      end else if (duty_q[i] < target[i]) begin
        st[i] = StRising;
      end else begin
        st[i] = StFalling;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  always_comb begin
    step_cnt_d = step_tick ? '0 : step_cnt_q + step_t'(1);
    pwm_cnt_d  = pwm_wrap  ? '0 : pwm_cnt_q + duty_t'(1);
  end

  // ---------------------------------------------------------------------------
  // Duty ramp, shadow load, PWM compare and status
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int unsigned i = 0; i < NumCh; i++) begin
      wide_t up;
      up          = {1'b0, duty_q[i]} + StepInc;
      duty_d[i]   = duty_q[i];
      shadow_d[i] = shadow_q[i];

      // A target flip mid-ramp simply changes the state; the next tick moves
      // from the current duty in the new direction.
      if (step_tick) begin
        unique case (st[i])
          StRising:  duty_d[i] = (up > DMaxW) ? DMax : up[PWM_BITS-1:0];
          StFalling: duty_d[i] = ({1'b0, duty_q[i]} < StepInc) ? '0
                                 : duty_q[i] - StepInc[PWM_BITS-1:0];
          StOff,
          StOn:      duty_d[i] = duty_q[i];
          default:   duty_d[i] = duty_q[i];
        endcase
      end

      // Shadow only changes at the period boundary so a period never mixes two
      // duty values. It samples duty_q, i.e. the value before any coincident step.
      if (pwm_wrap) begin
        shadow_d[i] = shade(duty_q[i]);
      end

      led_d[i]    = (pwm_cnt_q < shadow_q[i]);
      fading_d[i] = (duty_q[i] != target[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      pat_q      <= '0;
      step_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      led_q      <= '0;
      fading_q   <= '0;
      for (int unsigned i = 0; i < NumCh; i++) begin
        duty_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      pat_q      <= pattern_in;
      step_cnt_q <= step_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      led_q      <= led_d;
      fading_q   <= fading_d;
      for (int unsigned i = 0; i < NumCh; i++) begin
        duty_q[i]   <= duty_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign led_out = led_q;
  assign fading  = fading_q;

  always_comb begin
    duty_mon = '0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      duty_mon[i*PWM_BITS +: PWM_BITS] = duty_q[i];
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver with PWM_BITS=4, STEP_DIV=4 (DMAX=15, period 15).
// u_dut uses STEP_SIZE=1, u_dut4 uses STEP_SIZE=4 for the saturation check.
// Duty changes of u_dut are checked through a scoreboard of (value, cycle) pairs.

module tb_led_fade_driver;

  logic        clock = 1'b0;
  logic        n_reset = 1'b0;
  logic [3:0]  pattern_in = 4'hF;
  logic [3:0]  pat4 = 4'hF;
  logic [3:0]  led_out, fading, led4, fading4;
  logic [15:0] duty_mon, duty4;

  led_fade_driver #(.PWM_BITS(4), .STEP_DIV(4), .STEP_SIZE(1)) u_dut (
    .clock      (clock),
    .n_reset    (n_reset),
    .pattern_in (pattern_in),
    .led_out    (led_out),
    .fading     (fading),
    .duty_mon   (duty_mon)
  );

  led_fade_driver #(.PWM_BITS(4), .STEP_DIV(4), .STEP_SIZE(4)) u_dut4 (
    .clock      (clock),
    .n_reset    (n_reset),
    .pattern_in (pat4),
    .led_out    (led4),
    .fading     (fading4),
    .duty_mon   (duty4)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_cmp = 0;
  int n_mis = 0;
  int rel   = 0;

  typedef struct {
    logic [15:0] val;
    int          at;
  } exp_t;
  exp_t        sb_q[$];
  logic        sb_en = 1'b0;
  logic [15:0] prev = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc - rel);
    end
  endtask

  // Scoreboard consumer: every change of duty_mon must match the oldest entry.
  always @(negedge clock) begin
    if (sb_en && duty_mon !== prev) begin
      n_cmp++;
      assert (sb_q.size() > 0) else begin
        n_mis++;
        $error("FAIL sb_unexpected: observed duty_mon %h expected no change", duty_mon);
      end
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_duty", duty_mon, e.val);
        chk("sb_cycle", cyc, e.at);
      end
    end
    prev = duty_mon;
  end

  function automatic logic [14:0] exp_mask(input int d);
    int s;
    s = d;
`ifdef LED_FADE_GAMMA_EN
    if (d != 15) s = (d * d) >> 4;
`endif
    return 15'((32'd1 << s) - 1);
  endfunction

  task automatic push(input int k, input logic [15:0] v);
    exp_t e;
    e.val = v;
    e.at  = rel + 4 * k;
    sb_q.push_back(e);
  endtask

  task automatic do_reset(input int n, input logic [3:0] p, input logic [3:0] p4);
    @(negedge clock);
    sb_en      = 1'b0;
    n_reset    = 1'b0;
    pattern_in = p;
    pat4       = p4;
    repeat (n) @(negedge clock);
  endtask

  task automatic release_rst();
    n_reset = 1'b1;
    rel     = cyc;
    sb_en   = 1'b1;
  endtask

  // Advance to the negedge following release edge k (bounded).
  task automatic goto(input int k);
    int g;
    g = 0;
    while (cyc < rel + k && g < 1000) begin
      @(negedge clock);
      g++;
    end
    if (cyc != rel + k) chk("goto", cyc, rel + k);
  endtask

  // Capture led_out[ch] over one PWM period starting at edge k.
  task automatic period_mask(input int k, input int ch, output logic [14:0] m,
                             output logic [3:0] oth);
    m   = '0;
    oth = '0;
    goto(k);
    for (int i = 0; i < 15; i++) begin
      m[i] = led_out[ch];
      oth |= led_out & ~(4'b0001 << ch);
      @(negedge clock);
    end
  endtask

  logic [14:0] m, m1, m2;
  logic [3:0]  oth;
  logic [15:0] d4_exp [4] = '{16'h4, 16'h8, 16'hC, 16'hF};
  logic [15:0] tog_seq [16] = '{1, 2, 3, 4, 5, 4, 5, 4, 5, 4, 5, 4, 3, 2, 1, 0};

  initial begin
    // Reset held with an all-on pattern.
    repeat (3) @(negedge clock);
    chk("rst_led", led_out, 4'h0);
    chk("rst_fading", fading, 4'h0);
    chk("rst_duty", duty_mon, 16'h0);
    chk("rst_duty4", duty4, 16'h0);
    release_rst();
    push(1, 16'h1111);
    push(2, 16'h2222);
    goto(1);
    chk("fading_r1", fading, 4'h0);
    goto(2);
    chk("fading_r2", fading, 4'hF);
    chk("fading4_r2", fading4, 4'hF);
    goto(10);
    chk("sb_drained_a", sb_q.size(), 0);

    // Reset mid-fade clears all ramp state.
    do_reset(2, 4'h1, 4'h1);
    chk("midrst_duty", duty_mon, 16'h0);
    chk("midrst_fading", fading, 4'h0);
    chk("midrst_duty4", duty4, 16'h0);

    // Full rise on channel 0, and STEP_SIZE=4 saturation on u_dut4.
    release_rst();
    for (int k = 1; k <= 15; k++) push(k, 16'(k));
    for (int k = 1; k <= 4; k++) begin
      goto(4 * k);
      chk("step4_duty", duty4, d4_exp[k-1]);
    end
    period_mask(16, 0, m, oth);
    chk("rise_p1", m, exp_mask(3));
    chk("rise_p1_oth", oth, 4'h0);
    chk("step4_sat", duty4, 16'hF);
    period_mask(31, 0, m, oth);
    chk("rise_p2", m, exp_mask(7));
    period_mask(46, 0, m, oth);
    chk("rise_p3", m, exp_mask(11));
    chk("rise_fading_done", fading, 4'h0);
    chk("step4_fading_done", fading4, 4'h0);
    period_mask(61, 0, m, oth);
    chk("rise_p4_coincident", m, exp_mask(14));
    period_mask(76, 0, m, oth);
    chk("rise_full_on", m, exp_mask(15));
    chk("rise_full_oth", oth, 4'h0);
    chk("sb_drained_b", sb_q.size(), 0);

    // Mid-ramp reversal at duty 6.
    do_reset(2, 4'h1, 4'h0);
    release_rst();
    for (int k = 1; k <= 6; k++) push(k, 16'(k));
    for (int k = 7; k <= 12; k++) push(k, 16'(12 - k));
    goto(24);
    chk("rev_at6", duty_mon, 16'h6);
    pattern_in = 4'h0;
    period_mask(31, 0, m, oth);
    chk("rev_p2", m, exp_mask(5));
    goto(48);
    chk("rev_fading_48", fading, 4'h1);
    goto(49);
    chk("rev_fading_49", fading, 4'h0);
    period_mask(61, 0, m, oth);
    chk("rev_off_p1", m, 15'h0);
    period_mask(76, 0, m, oth);
    chk("rev_off_p2", m, 15'h0);
    chk("sb_drained_c", sb_q.size(), 0);

    // Hover around duty 5 by toggling the pattern after each tick.
    do_reset(2, 4'h1, 4'h0);
    release_rst();
    for (int k = 1; k <= 16; k++) push(k, tog_seq[k-1]);
    m1 = '0;
    m2 = '0;
    for (int c = 20; c <= 60; c++) begin
      goto(c);
      if (c % 4 == 0 && c <= 44) pattern_in = ((c / 4) % 2 == 0) ? 4'h1 : 4'h0;
      if (c >= 31 && c <= 45) m1[c-31] = led_out[0];
      if (c >= 46) m2[c-46] = led_out[0];
    end
    chk("hold5_p1", m1, exp_mask(5));
    chk("hold5_p2", m2, exp_mask(5));
    goto(65);
    chk("sb_drained_d", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
